// File: rtl/rsa_engine_arbiter_if.sv
// Request/response and engine-side bus of the shared modexp arbiter.
// The arbiter sits on the slave modport; clients plus the engine model sit on master.
interface rsa_engine_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 32
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_msg;
    logic [NUM_REQ*WIDTH-1:0] req_exp;
    logic [NUM_REQ*WIDTH-1:0] req_mod;

    logic [NUM_REQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]         rsp_data;
    logic                     rsp_err;

    logic                     eng_start;
    logic [WIDTH-1:0]         eng_msg;
    logic [WIDTH-1:0]         eng_exp;
    logic [WIDTH-1:0]         eng_mod;
    logic                     eng_done;
    logic [WIDTH-1:0]         eng_result;

    modport slave (
        input  req_valid, req_msg, req_exp, req_mod, eng_done, eng_result,
        output req_ready, rsp_valid, rsp_data, rsp_err,
               eng_start, eng_msg, eng_exp, eng_mod
    );

    modport master (
        output req_valid, req_msg, req_exp, req_mod, eng_done, eng_result,
        input  req_ready, rsp_valid, rsp_data, rsp_err,
               eng_start, eng_msg, eng_exp, eng_mod
    );
endinterface

// File: rtl/rsa_engine_arbiter.sv
// Round-robin sharing of one modexp engine among NUM_REQ requesters, with a
// watchdog that aborts a job whose engine never reports done.
module rsa_engine_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned TIMEOUT_CYC = 4096,
    parameter int unsigned CW          = 13,
    localparam int unsigned IW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    rsa_engine_arbiter_if.slave  bus,
    output logic                 busy,
    output logic [IW-1:0]        grant_id
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    localparam logic [IW:0]    NumReqW = (IW + 1)'(NUM_REQ);
    localparam logic [CW-1:0]  WdLast  = CW'(TIMEOUT_CYC - 1);
    localparam logic [WIDTH-1:0] ModMin = WIDTH'(2);

    state_e               state_q, state_d;
    logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]        grant_id_q, grant_id_d;
    logic [CW-1:0]        wd_q, wd_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 err_q, err_d;
    logic                 busy_q, busy_d;

    logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]     rsp_data_q, rsp_data_d;
    logic                 rsp_err_q, rsp_err_d;
    logic                 eng_start_q, eng_start_d;
    logic [WIDTH-1:0]     eng_msg_q, eng_msg_d;
    logic [WIDTH-1:0]     eng_exp_q, eng_exp_d;
    logic [WIDTH-1:0]     eng_mod_q, eng_mod_d;

    // Per-requester operand views of the flattened buses.
    logic [WIDTH-1:0]     msg_arr [NUM_REQ];
    logic [WIDTH-1:0]     exp_arr [NUM_REQ];
    logic [WIDTH-1:0]     mod_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign msg_arr[g] = bus.req_msg[g*WIDTH +: WIDTH];
        assign exp_arr[g] = bus.req_exp[g*WIDTH +: WIDTH];
        assign mod_arr[g] = bus.req_mod[g*WIDTH +: WIDTH];
    end

    // Round-robin pick: rotate valids so rr_ptr lands at bit 0, take the lowest set bit.
    logic [2*NUM_REQ-1:0] rot_valid;
    logic                 pick_found;
    logic [IW-1:0]        pick_off;
    logic [IW:0]          pick_sum;
    logic [IW-1:0]        pick_id;
    logic [IW:0]          next_sum;
    logic [IW-1:0]        next_ptr;

    always_comb begin
        rot_valid  = {bus.req_valid, bus.req_valid} >> rr_ptr_q;
        pick_found = 1'b0;
        pick_off   = '0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            if (rot_valid[k]) begin
                pick_found = 1'b1;
                pick_off   = k[IW-1:0];
            end
        end

        pick_sum = {1'b0, rr_ptr_q} + {1'b0, pick_off};
        if (pick_sum >= NumReqW) begin
            pick_sum = pick_sum - NumReqW;
        end
        pick_id = pick_sum[IW-1:0];

        next_sum = {1'b0, pick_id} + (IW + 1)'(1);
        if (next_sum >= NumReqW) begin
            next_sum = '0;
        end
        next_ptr = next_sum[IW-1:0];
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        wd_d        = wd_q;
        result_d    = result_q;
        err_d       = err_q;
        eng_msg_d   = eng_msg_q;
        eng_exp_d   = eng_exp_q;
        eng_mod_d   = eng_mod_q;
        req_ready_d = '0;
        rsp_valid_d = '0;
        rsp_data_d  = '0;
        rsp_err_d   = 1'b0;
        eng_start_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    req_ready_d[pick_id] = 1'b1;
                    eng_msg_d            = msg_arr[pick_id];
                    eng_exp_d            = exp_arr[pick_id];
                    eng_mod_d            = mod_arr[pick_id];
                    grant_id_d           = pick_id;
                    rr_ptr_d             = next_ptr;
                    state_d              = StIssue;
                end
            end
            StIssue: begin
                wd_d = '0;
                // A modulus below 2 has no meaningful result; skip the engine entirely.
                if (eng_mod_q < ModMin) begin
                    err_d    = 1'b1;
                    result_d = '0;
                    state_d  = StResp;
                end else begin
                    eng_start_d = 1'b1;
                    state_d     = StWait;
                end
            end
            StWait: begin
                wd_d = wd_q + 1'b1;
                if (bus.eng_done) begin
                    result_d = bus.eng_result;
                    err_d    = 1'b0;
                    state_d  = StResp;
                end else if (wd_q == WdLast) begin
                    err_d    = 1'b1;
                    result_d = '0;
                    state_d  = StResp;
                end
            end
            StResp: begin
                rsp_valid_d[grant_id_q] = 1'b1;
                rsp_data_d              = result_q;
                rsp_err_d               = err_q;
                state_d                 = StIdle;
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            wd_q        <= '0;
            result_q    <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            eng_start_q <= 1'b0;
            eng_msg_q   <= '0;
            eng_exp_q   <= '0;
            eng_mod_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            wd_q        <= wd_d;
            result_q    <= result_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            eng_start_q <= eng_start_d;
            eng_msg_q   <= eng_msg_d;
            eng_exp_q   <= eng_exp_d;
            eng_mod_q   <= eng_mod_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.eng_start = eng_start_q;
    assign bus.eng_msg   = eng_msg_q;
    assign bus.eng_exp   = eng_exp_q;
    assign bus.eng_mod   = eng_mod_q;
    assign busy          = busy_q;
    assign grant_id      = grant_id_q;

endmodule

// File: tb/tb_rsa_engine_arbiter.sv
// Directed bench for rsa_engine_arbiter: a default-timeout instance and a
// 16-cycle-timeout instance share the same stimulus; one is observed at a time.
module tb_rsa_engine_arbiter;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [3:0]   req_valid = '0;
    logic [127:0] req_msg = '0;
    logic [127:0] req_exp = '0;
    logic [127:0] req_mod = '0;
    logic         eng_done = 1'b0;
    logic [31:0]  eng_result = '0;

    logic         busy_a, busy_b;
    logic [1:0]   gid_a, gid_b;
    bit           use_b = 1'b0;

    int           n_checks = 0;
    int           n_pass = 0;
    int           cyc = 0;
    int           eng_lat = -1;
    int           eng_cnt = 0;
    logic [31:0]  eng_val = '0;

    always #5 clk = ~clk;

    rsa_engine_arbiter_if #(.NUM_REQ(4), .WIDTH(32)) ifa ();
    rsa_engine_arbiter_if #(.NUM_REQ(4), .WIDTH(32)) ifb ();

    assign ifa.req_valid  = req_valid;
    assign ifa.req_msg    = req_msg;
    assign ifa.req_exp    = req_exp;
    assign ifa.req_mod    = req_mod;
    assign ifa.eng_done   = eng_done;
    assign ifa.eng_result = eng_result;
    assign ifb.req_valid  = req_valid;
    assign ifb.req_msg    = req_msg;
    assign ifb.req_exp    = req_exp;
    assign ifb.req_mod    = req_mod;
    assign ifb.eng_done   = eng_done;
    assign ifb.eng_result = eng_result;

    rsa_engine_arbiter #(.NUM_REQ(4), .WIDTH(32), .TIMEOUT_CYC(4096), .CW(13)) dut_a (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (ifa),
        .busy     (busy_a),
        .grant_id (gid_a)
    );

    rsa_engine_arbiter #(.NUM_REQ(4), .WIDTH(32), .TIMEOUT_CYC(16), .CW(5)) dut_b (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (ifb),
        .busy     (busy_b),
        .grant_id (gid_b)
    );

    logic [3:0]  s_ready, s_rsp_valid;
    logic [31:0] s_rsp_data, s_eng_msg, s_eng_exp, s_eng_mod;
    logic        s_rsp_err, s_eng_start, s_busy;
    logic [1:0]  s_gid;

    assign s_ready     = use_b ? ifb.req_ready : ifa.req_ready;
    assign s_rsp_valid = use_b ? ifb.rsp_valid : ifa.rsp_valid;
    assign s_rsp_data  = use_b ? ifb.rsp_data  : ifa.rsp_data;
    assign s_rsp_err   = use_b ? ifb.rsp_err   : ifa.rsp_err;
    assign s_eng_start = use_b ? ifb.eng_start : ifa.eng_start;
    assign s_eng_msg   = use_b ? ifb.eng_msg   : ifa.eng_msg;
    assign s_eng_exp   = use_b ? ifb.eng_exp   : ifa.eng_exp;
    assign s_eng_mod   = use_b ? ifb.eng_mod   : ifa.eng_mod;
    assign s_busy      = use_b ? busy_b : busy_a;
    assign s_gid       = use_b ? gid_b : gid_a;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance to the next falling edge, then update the engine model and requesters.
    task automatic tick();
        @(negedge clk);
        cyc++;
        eng_done = 1'b0;
        if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                eng_done   = 1'b1;
                eng_result = eng_val;
            end
        end
        if (s_eng_start && eng_lat > 0) eng_cnt = eng_lat;
        req_valid = req_valid & ~s_ready;
    endtask

    task automatic set_req(input int i, input logic [31:0] m, input logic [31:0] e,
                           input logic [31:0] n);
        req_msg[i*32 +: 32] = m;
        req_exp[i*32 +: 32] = e;
        req_mod[i*32 +: 32] = n;
    endtask

    task automatic do_reset();
        req_valid = '0;
        eng_done  = 1'b0;
        eng_cnt   = 0;
        eng_lat   = -1;
        reset_n   = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic wait_ready(input int budget, output int id, output int t_acc);
        int n = 0;
        while (s_ready == '0 && n < budget) begin
            tick();
            n++;
        end
        check("ready_seen", 32'(|s_ready), 32'd1);
        id = -1;
        for (int i = 0; i < 4; i++) if (s_ready[i]) id = i;
        t_acc = cyc;
    endtask

    task automatic wait_rsp(input int budget);
        int n = 0;
        while (s_rsp_valid == '0 && n < budget) begin
            tick();
            n++;
        end
        check("rsp_seen", 32'(|s_rsp_valid), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int id, t0;
        int exp_a [4];
        int exp_b [4];
        bit seen_rsp, seen_busy, seen_ready;

        // Reset values
        tick();
        check("rst_ready", 32'(s_ready), 32'h0);
        check("rst_rsp_valid", 32'(s_rsp_valid), 32'h0);
        check("rst_eng_start", 32'(s_eng_start), 32'h0);
        check("rst_busy", 32'(s_busy), 32'h0);
        check("rst_eng_mod", s_eng_mod, 32'h0);

        // Single job on requester 2, engine latency 20
        do_reset();
        set_req(2, 32'd4, 32'd13, 32'd497);
        eng_lat = 20;
        eng_val = 32'd445;
        req_valid = 4'b0100;
        wait_ready(10, id, t0);
        check("j1_ready", 32'(s_ready), 32'h4);
        check("j1_grant", 32'(s_gid), 32'd2);
        check("j1_busy", 32'(s_busy), 32'd1);
        check("j1_eng_msg", s_eng_msg, 32'd4);
        check("j1_eng_exp", s_eng_exp, 32'd13);
        check("j1_eng_mod", s_eng_mod, 32'd497);
        check("j1_no_early_start", 32'(s_eng_start), 32'd0);
        tick();
        check("j1_start", 32'(s_eng_start), 32'd1);
        tick();
        check("j1_start_pulse", 32'(s_eng_start), 32'd0);
        check("j1_ops_hold", s_eng_mod, 32'd497);
        wait_rsp(100);
        check("j1_rsp_valid", 32'(s_rsp_valid), 32'h4);
        check("j1_rsp_data", s_rsp_data, 32'd445);
        check("j1_rsp_err", 32'(s_rsp_err), 32'd0);
        check("j1_latency", 32'(cyc - t0), 32'd23);
        tick();
        check("j1_rsp_pulse", 32'(s_rsp_valid), 32'h0);
        check("j1_idle", 32'(s_busy), 32'd0);

        // All four held from rr_ptr=0: order 0,1,2,3
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 32'(i + 5), 32'd3, 32'd97);
        exp_a = '{0, 1, 2, 3};
        eng_lat = 3;
        eng_val = 32'd11;
        req_valid = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            wait_ready(10, id, t0);
            check("rr1_grant", 32'(id), 32'(exp_a[k]));
            check("rr1_eng_msg", s_eng_msg, 32'(exp_a[k] + 5));
            wait_rsp(20);
            check("rr1_rsp_id", 32'(s_rsp_valid), 32'(1 << exp_a[k]));
        end

        // rr_ptr moved to 2 by one job on requester 1, then 2,3,0,1 with re-requests
        do_reset();
        eng_lat = 3;
        req_valid = 4'b0010;
        wait_ready(10, id, t0);
        wait_rsp(20);
        tick();
        req_valid = 4'b1111;
        exp_b = '{2, 3, 0, 1};
        for (int k = 0; k < 4; k++) begin
            wait_ready(10, id, t0);
            check("rr2_grant", 32'(id), 32'(exp_b[k]));
            wait_rsp(20);
            tick();
            if (k < 3) req_valid[id] = 1'b1;
        end

        // mod=1: error response two cycles after acceptance, engine untouched
        do_reset();
        set_req(1, 32'd3, 32'd5, 32'd1);
        eng_lat = 5;
        req_valid = 4'b0010;
        wait_ready(10, id, t0);
        check("bad_ready", 32'(s_ready), 32'h2);
        tick();
        check("bad_no_start1", 32'(s_eng_start), 32'd0);
        check("bad_no_rsp_yet", 32'(s_rsp_valid), 32'h0);
        tick();
        check("bad_no_start2", 32'(s_eng_start), 32'd0);
        check("bad_rsp_valid", 32'(s_rsp_valid), 32'h2);
        check("bad_rsp_err", 32'(s_rsp_err), 32'd1);
        check("bad_rsp_data", s_rsp_data, 32'd0);

        // Watchdog on the 16-cycle instance
        use_b = 1'b1;
        do_reset();
        set_req(0, 32'd2, 32'd7, 32'd97);
        eng_lat = -1;
        req_valid = 4'b0001;
        wait_ready(10, id, t0);
        wait_rsp(40);
        check("to_rsp_valid", 32'(s_rsp_valid), 32'h1);
        check("to_rsp_err", 32'(s_rsp_err), 32'd1);
        check("to_rsp_data", s_rsp_data, 32'd0);
        check("to_latency", 32'(cyc - t0), 32'd18);
        // Next job, done lands on the last WAIT cycle: done beats timeout
        set_req(3, 32'd9, 32'd0, 32'd101);
        eng_lat = 15;
        eng_val = 32'h0000_dead;
        req_valid = 4'b1000;
        wait_ready(10, id, t0);
        check("to2_ready", 32'(s_ready), 32'h8);
        check("to2_exp_zero", s_eng_exp, 32'd0);
        wait_rsp(40);
        check("to2_rsp_err", 32'(s_rsp_err), 32'd0);
        check("to2_rsp_data", s_rsp_data, 32'h0000_dead);
        check("to2_latency", 32'(cyc - t0), 32'd18);
        use_b = 1'b0;

        // Async reset mid-WAIT; late engine done afterwards must be ignored
        do_reset();
        set_req(2, 32'd4, 32'd13, 32'd497);
        eng_lat = 30;
        req_valid = 4'b0100;
        wait_ready(10, id, t0);
        repeat (5) tick();
        reset_n = 1'b0;
        #1;
        check("ar_busy", 32'(s_busy), 32'd0);
        check("ar_grant", 32'(s_gid), 32'd0);
        check("ar_eng_mod", s_eng_mod, 32'd0);
        check("ar_eng_msg", s_eng_msg, 32'd0);
        tick();
        reset_n = 1'b1;
        seen_rsp  = 1'b0;
        seen_busy = 1'b0;
        repeat (40) begin
            tick();
            if (s_rsp_valid != '0) seen_rsp = 1'b1;
            if (s_busy) seen_busy = 1'b1;
        end
        check("ar_no_rsp", 32'(seen_rsp), 32'd0);
        check("ar_no_busy", 32'(seen_busy), 32'd0);

        // Stray done while idle, then a request withdrawn before it could be granted
        do_reset();
        tick();
        eng_done = 1'b1;
        eng_result = 32'h1234;
        seen_rsp  = 1'b0;
        seen_busy = 1'b0;
        repeat (5) begin
            tick();
            if (s_rsp_valid != '0) seen_rsp = 1'b1;
            if (s_busy) seen_busy = 1'b1;
        end
        check("stray_no_rsp", 32'(seen_rsp), 32'd0);
        check("stray_no_busy", 32'(seen_busy), 32'd0);
        set_req(0, 32'd6, 32'd2, 32'd97);
        eng_lat = 10;
        eng_val = 32'd36;
        req_valid = 4'b0001;
        wait_ready(10, id, t0);
        check("wd_grant0", 32'(s_gid), 32'd0);
        tick();
        req_valid[3] = 1'b1;
        repeat (3) tick();
        req_valid[3] = 1'b0;
        wait_rsp(30);
        check("wd_rsp_valid", 32'(s_rsp_valid), 32'h1);
        check("wd_rsp_data", s_rsp_data, 32'd36);
        seen_ready = 1'b0;
        seen_busy  = 1'b0;
        repeat (10) begin
            tick();
            if (s_ready != '0) seen_ready = 1'b1;
            if (s_busy) seen_busy = 1'b1;
        end
        check("wd_no_grant", 32'(seen_ready), 32'd0);
        check("wd_no_busy", 32'(seen_busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
